// File: rtl/flash_adc_sequencer.sv
// ============================================================================
// Module   : flash_adc_sequencer
// Purpose  : One-shot / auto-triggered 3-bit flash ADC conversion controller
//            with registered thermometer encoding and valid/ready output.
//            Build macro ADC_BUBBLE_CORRECT_EN selects popcount encoding.
// Revision : 1.0
// ============================================================================
`default_nettype none

module flash_adc_sequencer #(
  parameter int SETTLE_CYCLES = 4,
  parameter int PERIOD        = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       auto_en,
  input  logic [7:0] cmp_in,
  output logic       sh_en,
  output logic       busy,
  output logic [2:0] dout,
  output logic       dout_valid,
  input  logic       dout_ready,
  output logic       bubble_err,
  output logic       overrun
);

  localparam logic [1:0]  c_st_idle     = 2'd0;
  localparam logic [1:0]  c_st_settle   = 2'd1;
  localparam logic [1:0]  c_st_capture  = 2'd2;
  localparam logic [1:0]  c_st_output   = 2'd3;
  localparam logic [7:0]  c_settle_load = 8'(SETTLE_CYCLES - 1);
  localparam logic [15:0] c_period_last = 16'(PERIOD - 1);

  logic [1:0]  r_state;
  logic [1:0]  w_next_state;
  logic [7:0]  r_settle_cnt;
  logic [15:0] r_period_cnt;
  logic        w_tick;
  logic        w_trigger;
  logic [2:0]  w_enc;
  logic        w_bubble;
  logic [2:0]  r_dout;
  logic        r_bubble;
  logic        r_dout_valid;
  logic        r_overrun;

  assign w_tick    = auto_en && (r_period_cnt == c_period_last);
  assign w_trigger = start | w_tick;

`ifdef ADC_BUBBLE_CORRECT_EN
  logic [3:0] w_ones;

  // Counting ones tolerates isolated bubbles in the comparator bank.
  always_comb begin
    w_ones = 4'd0;
    for (int i = 0; i < 8; i++) begin
      w_ones = w_ones + {3'd0, cmp_in[i]};
    end
    w_enc = (w_ones == 4'd0) ? 3'd0 : 3'(w_ones - 4'd1);
  end
`else
  always_comb begin
    w_enc = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (cmp_in[i]) begin
        w_enc = 3'(i);
      end
    end
  end
`endif

  // A code of the form 2^k-1 has no bit overlapping its own successor.
  assign w_bubble = ((cmp_in + 8'd1) & cmp_in) != 8'd0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_st_idle;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_st_idle:    if (w_trigger) w_next_state = c_st_settle;
      c_st_settle:  if (r_settle_cnt == 8'd0) w_next_state = c_st_capture;
      c_st_capture: w_next_state = c_st_output;
      c_st_output:  if (r_dout_valid && dout_ready) w_next_state = c_st_idle;
      default:      w_next_state = c_st_idle;
    endcase
  end

  always_comb begin
    sh_en = (r_state == c_st_settle) || (r_state == c_st_capture);
    busy  = (r_state != c_st_idle);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_settle_cnt <= 8'd0;
      r_dout       <= 3'd0;
      r_bubble     <= 1'b0;
      r_dout_valid <= 1'b0;
    end else begin
      if (r_state == c_st_idle && w_trigger) begin
        r_settle_cnt <= c_settle_load;
      end else if (r_state == c_st_settle && r_settle_cnt != 8'd0) begin
        r_settle_cnt <= r_settle_cnt - 8'd1;
      end
      if (r_state == c_st_capture) begin
        r_dout       <= w_enc;
        r_bubble     <= w_bubble;
        r_dout_valid <= 1'b1;
      end else if (r_state == c_st_output && r_dout_valid && dout_ready) begin
        r_dout_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_period_cnt <= 16'd0;
      r_overrun    <= 1'b0;
    end else begin
      if (!auto_en || w_tick) begin
        r_period_cnt <= 16'd0;
      end else begin
        r_period_cnt <= r_period_cnt + 16'd1;
      end
      if (!auto_en) begin
        r_overrun <= 1'b0;
      end else if (w_tick && r_state != c_st_idle) begin
        r_overrun <= 1'b1;
      end
    end
  end

  assign dout       = r_dout;
  assign bubble_err = r_bubble;
  assign dout_valid = r_dout_valid;
  assign overrun    = r_overrun;

endmodule

`default_nettype wire

// File: tb/tb_flash_adc_sequencer.sv
// ============================================================================
// Module   : tb_flash_adc_sequencer
// Purpose  : Self-checking bench for flash_adc_sequencer (vector table,
//            randomized conversions, auto mode, overrun and reset abort).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_flash_adc_sequencer;

  localparam int S = 4;
  localparam int P = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       auto_en;
  logic [7:0] cmp_in;
  logic       sh_en;
  logic       busy;
  logic [2:0] dout;
  logic       dout_valid;
  logic       dout_ready;
  logic       bubble_err;
  logic       overrun;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] cmp;
    logic [2:0] exp_dout;
    logic       exp_bub;
  } vec_t;

  vec_t vecs[8];

  flash_adc_sequencer #(.SETTLE_CYCLES(S), .PERIOD(P)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .auto_en    (auto_en),
    .cmp_in     (cmp_in),
    .sh_en      (sh_en),
    .busy       (busy),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .bubble_err (bubble_err),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Reference: result index from the code's value range / set-bit count.
  function automatic logic [2:0] model_dout(input logic [7:0] v);
    int n;
`ifdef ADC_BUBBLE_CORRECT_EN
    n = $countones(v) - 1;
`else
    n = $clog2(int'(v) + 1) - 1;
`endif
    if (n < 0) n = 0;
    return 3'(n);
  endfunction

  function automatic logic model_bub(input logic [7:0] v);
    return $countones(v) != $clog2(int'(v) + 1);
  endfunction

  task automatic run_txn(input logic [7:0] cmp_final, input logic [2:0] exp_dout,
                         input logic exp_bub, input int hold, input string tag);
    int   sh_cnt = 0;
    logic early  = 1'b0;
    logic stable = 1'b1;
    dout_ready = 1'b0;
    start      = 1'b1;
    cmp_in     = 8'($urandom);
    step();
    start = 1'b0;
    chk({tag, "_busy_after_start"}, 32'(busy), 32'd1);
    for (int k = 1; k <= S; k++) begin
      if (sh_en) sh_cnt++;
      if (dout_valid) early = 1'b1;
      cmp_in = 8'($urandom);
      start  = 1'($urandom_range(0, 1));
      step();
    end
    if (sh_en) sh_cnt++;
    if (dout_valid) early = 1'b1;
    cmp_in = cmp_final;
    start  = 1'($urandom_range(0, 1));
    step();
    start = 1'b0;
    chk({tag, "_valid_early"}, 32'(early), 32'd0);
    chk({tag, "_sh_en_cycles"}, 32'(sh_cnt), 32'(S + 1));
    chk({tag, "_valid_latency"}, 32'(dout_valid), 32'd1);
    chk({tag, "_sh_en_off"}, 32'(sh_en), 32'd0);
    chk({tag, "_dout"}, 32'(dout), 32'(exp_dout));
    chk({tag, "_bubble"}, 32'(bubble_err), 32'(exp_bub));
    for (int d = 0; d < hold; d++) begin
      cmp_in = 8'($urandom);
      start  = (d == 2);
      step();
      if (dout !== exp_dout || bubble_err !== exp_bub || dout_valid !== 1'b1) stable = 1'b0;
    end
    start = 1'b0;
    chk({tag, "_hold_stable"}, 32'(stable), 32'd1);
    dout_ready = 1'b1;
    step();
    dout_ready = 1'b0;
    chk({tag, "_valid_cleared"}, 32'(dout_valid), 32'd0);
    chk({tag, "_idle_after_accept"}, 32'(busy), 32'd0);
    step();
    chk({tag, "_stays_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int          rises[$];
    int          vrises;
    logic        prev_busy;
    logic        prev_valid;
    logic        ok;
    logic        found;
    logic [7:0]  v;

    vecs[0] = '{8'h1F, 3'd4, 1'b0};
    vecs[1] = '{8'h00, 3'd0, 1'b0};
    vecs[2] = '{8'hFF, 3'd7, 1'b0};
    vecs[4] = '{8'h01, 3'd0, 1'b0};
    vecs[5] = '{8'h3F, 3'd5, 1'b0};
`ifdef ADC_BUBBLE_CORRECT_EN
    vecs[3] = '{8'h2F, 3'd4, 1'b1};
    vecs[6] = '{8'h80, 3'd0, 1'b1};
    vecs[7] = '{8'h55, 3'd3, 1'b1};
`else
    vecs[3] = '{8'h2F, 3'd5, 1'b1};
    vecs[6] = '{8'h80, 3'd7, 1'b1};
    vecs[7] = '{8'h55, 3'd6, 1'b1};
`endif

    rst_n = 1'b0; start = 1'b0; auto_en = 1'b0; cmp_in = 8'h00; dout_ready = 1'b0;
    step(); step();
    chk("reset_outputs", {26'd0, sh_en, busy, dout_valid, bubble_err, overrun, 1'b0} |
        {29'd0, dout}, 32'd0);
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 8; i++) begin
      run_txn(vecs[i].cmp, vecs[i].exp_dout, vecs[i].exp_bub, (i == 3) ? 10 : 0,
              $sformatf("vec%0d", i));
    end

    for (int t = 0; t < 40; t++) begin
      v = 8'($urandom);
      if ($urandom_range(0, 3) == 0) v = v >> $urandom_range(0, 8) | 8'h00;
      if ($urandom_range(0, 3) == 0) v = 8'hFF >> $urandom_range(0, 8);
      for (int g = 0; g < int'($urandom_range(0, 3)); g++) step();
      run_txn(v, model_dout(v), model_bub(v), int'($urandom_range(0, 4)), "rnd");
    end

    // Auto mode: conversions start every P cycles after auto_en rises.
    cmp_in = 8'h07; dout_ready = 1'b1;
    auto_en = 1'b1;
    prev_busy = busy; prev_valid = dout_valid; vrises = 0;
    for (int c = 1; c <= 70; c++) begin
      step();
      if (busy && !prev_busy) rises.push_back(c);
      if (dout_valid && !prev_valid) vrises++;
      prev_busy = busy; prev_valid = dout_valid;
    end
    chk("auto_conv_count", 32'(rises.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("auto_start_cycle%0d", i), 32'((i < rises.size()) ? rises[i] : -1),
          32'(P * (i + 1)));
    end
    chk("auto_results", 32'(vrises), 32'd4);
    chk("auto_no_overrun", 32'(overrun), 32'd0);

    dout_ready = 1'b0;
    for (int c = 0; c < 40; c++) step();
    chk("overrun_set", 32'(overrun), 32'd1);
    dout_ready = 1'b1;
    ok = 1'b1;
    for (int c = 0; c < 10; c++) begin
      step();
      if (overrun !== 1'b1) ok = 1'b0;
    end
    chk("overrun_sticky", 32'(ok), 32'd1);

    // Abort in SETTLE: everything must drop as soon as rst_n falls.
    found = 1'b0;
    for (int c = 0; c < 40 && !found; c++) begin
      step();
      if (sh_en && dout_valid === 1'b0) found = 1'b1;
    end
    chk("wait_settle", 32'(found), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_sh_en", 32'(sh_en), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_valid", 32'(dout_valid), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    auto_en = 1'b0;
    step();
    rst_n = 1'b1;
    ok = 1'b1;
    for (int c = 0; c < 20; c++) begin
      step();
      if (dout_valid !== 1'b0 || busy !== 1'b0) ok = 1'b0;
    end
    chk("no_result_after_abort", 32'(ok), 32'd1);

    dout_ready = 1'b0;
    auto_en = 1'b1;
    for (int c = 0; c < 40; c++) step();
    chk("overrun_again", 32'(overrun), 32'd1);
    auto_en = 1'b0;
    #1;
    chk("overrun_until_edge", 32'(overrun), 32'd1);
    step();
    chk("overrun_cleared", 32'(overrun), 32'd0);
    dout_ready = 1'b1;
    step();
    chk("drain_idle", 32'(busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
